// File: rtl/craft_decrypt.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// craft_decrypt
//   Round-based CRAFT decryption core (one round per clock, 32 rounds).
//   Relies on CRAFT's involutory structure: the encryption round shape
//   MC -> add constant/tweakey -> PN -> SB is reused. The round constants run in
//   reverse order and the tweakeys are pre-mixed through MixColumns.
//
//   Optional build macro: CRAFT_DEC_KEY_ZEROIZE_EN
//     When defined, the latched key, latched tweak and cipher state are wiped in
//     the same edge that enters DONE. The key_cleared status output is added.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        load inputs and begin; sampled only in IDLE
//   ciphertext   64-bit ciphertext, nibble 0 = bits [63:60]
//   tweak        64-bit tweak T
//   key          128-bit key K0||K1 (K0 = key[127:64])
//   busy         high while rounds are running (ROUND and FINAL)
//   done         one-cycle pulse; plaintext is valid from the same edge
//   plaintext    result, held until overwritten by the next operation
//   key_cleared  (macro only) set with done, cleared on the next accept
//   dbg_state    current FSM state: 0 IDLE, 1 ROUND, 2 FINAL, 3 DONE
//
// Handshake: start is a level that is honoured only while the FSM sits in
// IDLE. It is not queued, and it is ignored in the ROUND, FINAL and DONE
// states. There is no back-pressure on the result: done is a single-cycle
// pulse.
// -----------------------------------------------------------------------------
module craft_decrypt #(
  parameter int ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  ciphertext,
  input  logic [63:0]  tweak,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [63:0]  plaintext,
`ifdef CRAFT_DEC_KEY_ZEROIZE_EN
  output logic         key_cleared,
`endif
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Nibble tables, entry i held in bits [63-4i -: 4].
  localparam logic [63:0] PN_TAB   = 64'hfcdea98b65471230; // PermuteNibbles
  localparam logic [63:0] Q_TAB    = 64'hcaf5e892b374601d; // tweak permutation Q
  localparam logic [63:0] SBOX_TAB = 64'hcad3ebf789150246; // CRAFT S-box

  // The last full round index. The transition to FINAL happens after this round.
  localparam logic [4:0] LAST_FULL = 5'(ROUNDS - 2);

  // The encryptor's LFSRs start at a=1, b=1. After 31 steps they reach
  // a=8 (period 15) and b=5 (period 7). Round 0 of decryption needs
  // RC(31), so these values are the seed.
  localparam logic [3:0] SEED_A = 4'h8;
  localparam logic [2:0] SEED_B = 3'h5;

  state_t        state_q, state_d;
  logic [63:0]   s_q;
  logic [63:0]   tweak_q;
  logic [127:0]  key_q;
  logic [3:0]    lfsr_a_q;
  logic [2:0]    lfsr_b_q;
  logic [4:0]    rnd_q;

  // ---------------------------------------------------------------------------
  // Round primitives
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] mix_columns(input logic [63:0] s);
    logic [63:0] o;
    o = s;
    for (int j = 0; j < 4; j++) begin
      o[63-4*j -: 4]     = s[63-4*j -: 4] ^ s[63-4*(8+j) -: 4] ^ s[63-4*(12+j) -: 4];
      o[63-4*(4+j) -: 4] = s[63-4*(4+j) -: 4] ^ s[63-4*(12+j) -: 4];
    end
    return o;
  endfunction

  function automatic logic [63:0] nib_permute(input logic [63:0] s, input logic [63:0] tab);
    logic [63:0] o;
    logic [3:0]  src;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      src = tab[63-4*i -: 4];
      o[63-4*i -: 4] = s[63-4*int'(src) -: 4];
    end
    return o;
  endfunction

  function automatic logic [63:0] sub_cells(input logic [63:0] s);
    logic [63:0] o;
    logic [3:0]  v;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      v = s[63-4*i -: 4];
      o[63-4*i -: 4] = SBOX_TAB[63-4*int'(v) -: 4];
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Tweakeys: TK'j = MC(TKj), built straight from the latched key and tweak
  // ---------------------------------------------------------------------------
  logic [63:0] tweak_qp;
  logic [63:0] tk_dec [4];

  always_comb begin
    tweak_qp  = nib_permute(tweak_q, Q_TAB);
    tk_dec[0] = mix_columns(key_q[127:64] ^ tweak_q);
    tk_dec[1] = mix_columns(key_q[63:0]   ^ tweak_q);
    tk_dec[2] = mix_columns(key_q[127:64] ^ tweak_qp);
    tk_dec[3] = mix_columns(key_q[63:0]   ^ tweak_qp);
  end

  // ---------------------------------------------------------------------------
  // Round datapath
  // ---------------------------------------------------------------------------
  logic [63:0] rc_vec;
  logic [63:0] tk_sel;
  logic [63:0] round_add;
  logic [63:0] round_full;

  always_comb begin
    // a enters nibble 4, b enters the low three bits of nibble 5.
    // MC leaves row-1-only vectors unchanged, so the constant needs no premix.
    rc_vec     = {16'h0, lfsr_a_q, 1'b0, lfsr_b_q, 40'h0};
    // Round i uses TK'((31-i) mod 4), which equals the bitwise inverse of i[1:0].
    tk_sel     = tk_dec[~rnd_q[1:0]];
    round_add  = mix_columns(s_q) ^ rc_vec ^ tk_sel;
    round_full = sub_cells(nib_permute(round_add, PN_TAB));
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ROUND;
      S_ROUND: if (rnd_q == LAST_FULL) state_d = S_FINAL;
      S_FINAL: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_ROUND) || (state_q == S_FINAL);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q       <= '0;
      tweak_q   <= '0;
      key_q     <= '0;
      lfsr_a_q  <= '0;
      lfsr_b_q  <= '0;
      rnd_q     <= '0;
      plaintext <= '0;
`ifdef CRAFT_DEC_KEY_ZEROIZE_EN
      key_cleared <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            s_q      <= ciphertext;
            tweak_q  <= tweak;
            key_q    <= key;
            lfsr_a_q <= SEED_A;
            lfsr_b_q <= SEED_B;
            rnd_q    <= '0;
`ifdef CRAFT_DEC_KEY_ZEROIZE_EN
            key_cleared <= 1'b0;
`endif
          end
        end
        S_ROUND: begin
          s_q      <= round_full;
          rnd_q    <= rnd_q + 5'd1;
          // Backward step of the encryptor's LFSRs.
          lfsr_a_q <= {lfsr_a_q[2:0], lfsr_a_q[3] ^ lfsr_a_q[0]};
          lfsr_b_q <= {lfsr_b_q[1:0], lfsr_b_q[2] ^ lfsr_b_q[0]};
        end
        S_FINAL: begin
          // Half round: no PN, no SB.
          plaintext <= round_add;
`ifdef CRAFT_DEC_KEY_ZEROIZE_EN
          s_q         <= '0;
          tweak_q     <= '0;
          key_q       <= '0;
          lfsr_a_q    <= '0;
          lfsr_b_q    <= '0;
          key_cleared <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_craft_decrypt.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_craft_decrypt
//   Self-checking bench for craft_decrypt. A reference CRAFT encryptor, written
//   over nibble arrays, produces ciphertexts. The DUT must recover the original
//   plaintext with the expected timing.
// -----------------------------------------------------------------------------
module tb_craft_decrypt;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [63:0]  ciphertext;
  logic [63:0]  tweak;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [63:0]  plaintext;
  logic [1:0]   dbg_state;
`ifdef CRAFT_DEC_KEY_ZEROIZE_EN
  logic         key_cleared;
`endif

  always #5 clk = ~clk;

  craft_decrypt #(.ROUNDS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ciphertext (ciphertext),
    .tweak      (tweak),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .plaintext  (plaintext),
`ifdef CRAFT_DEC_KEY_ZEROIZE_EN
    .key_cleared(key_cleared),
`endif
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  // ---------------- reference model ----------------
  localparam int PTAB[16]  = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
  localparam int QTAB[16]  = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
  localparam int SBTAB[16] = '{12, 10, 13, 3, 14, 11, 15, 7, 8, 9, 1, 5, 0, 2, 4, 6};

  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [63:0] tw,
                                              input logic [127:0] k);
    logic [3:0]  st[16];
    logic [3:0]  tmp[16];
    logic [3:0]  t[16];
    logic [3:0]  tk[4][16];
    logic [63:0] o;
    int a;
    int b;
    for (int i = 0; i < 16; i++) begin
      st[i] = pt[63-4*i -: 4];
      t[i]  = tw[63-4*i -: 4];
    end
    for (int i = 0; i < 16; i++) begin
      tk[0][i] = k[127-4*i -: 4] ^ t[i];
      tk[1][i] = k[63-4*i -: 4]  ^ t[i];
      tk[2][i] = k[127-4*i -: 4] ^ t[QTAB[i]];
      tk[3][i] = k[63-4*i -: 4]  ^ t[QTAB[i]];
    end
    a = 1;
    b = 1;
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 4; c++) begin
        st[c]   = st[c] ^ st[8+c] ^ st[12+c];
        st[4+c] = st[4+c] ^ st[12+c];
      end
      st[4] = st[4] ^ 4'(a);
      st[5] = st[5] ^ 4'(b);
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ tk[r % 4][i];
      if (r < 31) begin
        for (int i = 0; i < 16; i++) tmp[i] = st[PTAB[i]];
        for (int i = 0; i < 16; i++) st[i] = 4'(SBTAB[tmp[i]]);
      end
      a = (a >> 1) | (((a ^ (a >> 1)) & 1) << 3);
      b = (b >> 1) | (((b ^ (b >> 1)) & 1) << 2);
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[63-4*i -: 4] = st[i];
    return o;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  // Present start with the given operands; the next rising edge samples them.
  task automatic drive_start(input logic [63:0] ct, input logic [63:0] tw, input logic [127:0] k);
    @(posedge clk); #1;
    start      = 1'b1;
    ciphertext = ct;
    tweak      = tw;
    key        = k;
  endtask

  // One complete operation, from start to done, with latency and result checks.
  // Inputs are scrambled right after the accept edge.
  task automatic run_op(input string name, input logic [63:0] pt, input logic [63:0] tw,
                        input logic [127:0] k);
    logic [63:0] e;
    int n;
    exp_q.push_back(pt);
    drive_start(ref_encrypt(pt, tw, k), tw, k);
    @(posedge clk); #1;
    start      = 1'b0;
    ciphertext = rnd64();
    tweak      = rnd64();
    key        = {rnd64(), rnd64()};
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_accept got %b exp 1", name, busy);
    end
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL %s latency got %0d exp 33", name, n);
    end
    checks++;
    if (plaintext !== e) begin
      errors++;
      $display("FAIL %s plaintext got %h exp %h", name, plaintext, e);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ciphertext = '0; tweak = '0; key = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (plaintext !== 64'h0) begin errors++; $display("FAIL reset_pt got %h exp 0", plaintext); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    run_op("zero_vec", 64'h0, 64'h0, 128'h0);
    run_op("known_vec", 64'h0123456789abcdef, 64'hfedcba9876543210,
           128'h000102030405060708090a0b0c0d0e0f);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) run_op("random", rnd64(), rnd64(), {rnd64(), rnd64()});
  endtask

  task automatic test_busy_protect();
    logic [63:0]  pt, tw;
    logic [127:0] k;
    int done_cnt;
    pt = rnd64(); tw = rnd64(); k = {rnd64(), rnd64()};
    drive_start(ref_encrypt(pt, tw, k), tw, k);
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n <= 32) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_hold cycle %0d got %b exp 1", n, busy); end
      end
      if (n == 33) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_drop got %b exp 0", busy); end
      end
      if (done === 1'b1) begin
        done_cnt++;
        checks++;
        if (n != 33) begin errors++; $display("FAIL busy_done_cycle got %0d exp 33", n); end
        checks++;
        if (plaintext !== pt) begin errors++; $display("FAIL busy_result got %h exp %h", plaintext, pt); end
      end
      if (n == 5 || n == 20) begin
        start = 1'b1; ciphertext = rnd64();
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL busy_done_count got %0d exp 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [63:0]  pt, tw;
    logic [127:0] k;
    int done_cnt;
    pt = rnd64(); tw = rnd64(); k = {rnd64(), rnd64()};
    drive_start(ref_encrypt(pt, tw, k), tw, k);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", done); end
    checks++; if (plaintext !== 64'h0) begin errors++; $display("FAIL midrst_pt got %h exp 0", plaintext); end
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", done_cnt); end
    run_op("after_reset", rnd64(), rnd64(), {rnd64(), rnd64()});
  endtask

  task automatic test_back_to_back();
    logic [63:0]  pts[3];
    logic [63:0]  tws[3];
    logic [127:0] ks[3];
    logic [63:0]  held, e;
    logic         prev_done;
    int idx, cyc, last, ndone;
    for (int i = 0; i < 3; i++) begin
      pts[i] = rnd64(); tws[i] = rnd64(); ks[i] = {rnd64(), rnd64()};
    end
    exp_q.delete();
    exp_q.push_back(pts[0]);
    drive_start(ref_encrypt(pts[0], tws[0], ks[0]), tws[0], ks[0]);
    idx = 1;
    @(posedge clk); #1;
    cyc = 1; last = 0; ndone = 0; prev_done = 1'b0; held = '0;
    while (ndone < 3 && cyc < 200) begin
      if (done === 1'b1) begin
        checks++;
        if (prev_done) begin errors++; $display("FAIL b2b_pulse_width done high two cycles"); end
        checks++;
        if (cyc - last != (ndone == 0 ? 33 : 34)) begin
          errors++;
          $display("FAIL b2b_interval got %0d exp %0d", cyc - last, (ndone == 0 ? 33 : 34));
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_queue unexpected done");
        end else begin
          e = exp_q.pop_front();
          if (plaintext !== e) begin errors++; $display("FAIL b2b_result got %h exp %h", plaintext, e); end
        end
        held = plaintext;
        last = cyc;
        ndone++;
        if (idx < 3) begin
          ciphertext = ref_encrypt(pts[idx], tws[idx], ks[idx]);
          tweak      = tws[idx];
          key        = ks[idx];
          exp_q.push_back(pts[idx]);
          idx++;
        end else begin
          start = 1'b0;
        end
      end else if (ndone > 0) begin
        checks++;
        if (plaintext !== held) begin errors++; $display("FAIL b2b_stable got %h exp %h", plaintext, held); end
      end
      prev_done = done;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (ndone != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", ndone); end
    repeat (3) @(posedge clk);
  endtask

`ifdef CRAFT_DEC_KEY_ZEROIZE_EN
  task automatic test_zeroize();
    int n;
    run_op("zeroize_op", rnd64(), rnd64(), {rnd64(), rnd64()});
    checks++; if (key_cleared !== 1'b1) begin errors++; $display("FAIL zero_flag got %b exp 1", key_cleared); end
    checks++; if (dut.key_q !== 128'h0) begin errors++; $display("FAIL zero_key got %h exp 0", dut.key_q); end
    checks++; if (dut.tweak_q !== 64'h0) begin errors++; $display("FAIL zero_tweak got %h exp 0", dut.tweak_q); end
    drive_start(rnd64(), rnd64(), {rnd64(), rnd64()});
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (key_cleared !== 1'b0) begin errors++; $display("FAIL zero_flag_clr got %b exp 0", key_cleared); end
    n = 0;
    while (done !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_second_done timeout"); end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_vectors();
    test_busy_protect();
    test_reset_mid();
    test_back_to_back();
`ifdef CRAFT_DEC_KEY_ZEROIZE_EN
    test_zeroize();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
